// File: rtl/ex_muldiv_if.sv
// EX-stage handshake between the pipeline and the iterative multiply/divide unit.
interface ex_muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] src1;
  logic [DATA_WIDTH-1:0] src2;
  logic [4:0]            rd;
  logic                  flush;
  logic                  stall;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic [4:0]            rd_out;

  modport master (
    output start, funct3, src1, src2, rd, flush,
    input  stall, done, result, rd_out
  );

  modport slave (
    input  start, funct3, src1, src2, rd, flush,
    output stall, done, result, rd_out
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: one shared 32-step shift-add / restoring-divide datapath.
// Freezes upstream while iterating; divide-by-zero and signed overflow finish one cycle after accept.
module ex_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]  b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic          s1_q, s1_d, s2_q, s2_d;
  logic [4:0]    rd_q, rd_d, rd_out_q, rd_out_d;
  logic [W-1:0]  result_q, result_d;

  logic           accept, last, fast, sgn1_in, sgn2_in, div0, ovf, qbit;
  logic [W-1:0]   mag1, mag2, fast_res, addend, quo, rem, fin_res;
  logic [W:0]     mul_sum, sh_rem, diff;
  logic [2*W-1:0] mul_next, div_next, step_acc, prod;

  assign accept = (state_q == IDLE) && bus.start && !bus.flush;
  assign last   = (state_q == CALC) && (cnt_q == CW'(W - 1));

  // Signed operands: MULH, MULHSU (rs1 only), DIV, REM
  assign sgn1_in = bus.src1[W-1] && (bus.funct3 == 3'b001 || bus.funct3 == 3'b010 ||
                                     bus.funct3 == 3'b100 || bus.funct3 == 3'b110);
  assign sgn2_in = bus.src2[W-1] && (bus.funct3 == 3'b001 || bus.funct3 == 3'b100 ||
                                     bus.funct3 == 3'b110);
  assign mag1    = sgn1_in ? -bus.src1 : bus.src1;
  assign mag2    = sgn2_in ? -bus.src2 : bus.src2;

  assign div0     = (bus.src2 == '0);
  assign ovf      = (bus.funct3 == 3'b100 || bus.funct3 == 3'b110) &&
                    (bus.src1 == {1'b1, {(W-1){1'b0}}}) && (bus.src2 == '1);
  assign fast     = bus.funct3[2] && (div0 || ovf);
  assign fast_res = div0 ? (bus.funct3[1] ? bus.src1 : '1)
                         : (bus.funct3[1] ? '0 : {1'b1, {(W-1){1'b0}}});

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
  assign addend   = acc_q[0] ? b_q : '0;
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, addend};
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step
  assign sh_rem   = {acc_q[2*W-1:W], acc_q[W-1]};
  assign diff     = sh_rem - {1'b0, b_q};
  assign qbit     = !diff[W];
  assign div_next = {(qbit ? diff[W-1:0] : sh_rem[W-1:0]), acc_q[W-2:0], qbit};

  assign step_acc = op_q[2] ? div_next : mul_next;
  assign prod     = (s1_q ^ s2_q) ? -step_acc : step_acc;
  assign quo      = (s1_q ^ s2_q) ? -step_acc[W-1:0] : step_acc[W-1:0];
  assign rem      = s1_q ? -step_acc[2*W-1:W] : step_acc[2*W-1:W];
  assign fin_res  = op_q[2] ? (op_q[1] ? rem : quo)
                            : ((op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = fast ? FIN : CALC;
      CALC:    if (last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  // stall is also masked during reset so a held start cannot leak through
  always_comb begin
    bus.stall = 1'b0;
    bus.done  = 1'b0;
    if (!rst && !bus.flush) begin
      bus.stall = (state_q == IDLE && bus.start) || (state_q == CALC);
      bus.done  = (state_q == FIN);
    end
  end

  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    result_d = result_q;
    if (accept) begin
      op_d  = bus.funct3;
      rd_d  = bus.rd;
      s1_d  = sgn1_in;
      s2_d  = sgn2_in;
      b_d   = mag2;
      acc_d = {{W{1'b0}}, mag1};
      cnt_d = '0;
      if (fast) begin
        result_d = fast_res;
        rd_out_d = bus.rd;
      end
    end else if (state_q == CALC && !bus.flush) begin
      acc_d = step_acc;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        result_d = fin_res;
        rd_out_d = rd_q;
      end
    end else if (state_q != CALC) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      rd_q     <= '0;
      rd_out_q <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      result_q <= result_d;
    end
  end
endmodule
